// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and sizing constants for the UART receiver
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx pin, idles high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with holding register and valid/read handshake
// Optional UART_RX_SYNC_EN inserts a two-flop synchronizer on rx.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      read_en,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int H = (CLKS_PER_BIT - 1) / 2;
  localparam logic [UART_CNT_W-1:0] BIT_LAST  = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_CNT_W-1:0] HALF_LAST = (H > 0) ? UART_CNT_W'(H - 1) : '0;
  localparam logic [2:0]            IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  uart_rx_state_t            state, state_n;
  logic [UART_CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]                bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      good_stop, bad_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // cnt counts cycles since the last sample point (or since start detection)
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          bit_idx_n = '0;
          // with H=0 the start sample is this very cycle and has already passed
          state_n   = (H == 0) ? ST_DATA : ST_START;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          good_stop = rx_s;
          bad_stop  = !rx_s;
          state_n   = rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (valid && read_en) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      // a read in the stop-sample cycle frees the register for the new byte
      if (good_stop) begin
        if (valid && !read_en) begin
          overrun <= 1'b1;
        end else begin
          data  <= shreg;
          valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver (default build, no synchronizer)
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx1 = 1'b1, re1 = 1'b0, rx16 = 1'b1, re16 = 1'b0;
  logic [7:0] data1, data16;
  logic valid1, busy1, ferr1, ovr1;
  logic valid16, busy16, ferr16, ovr16;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .read_en(re1), .data(data1),
    .valid(valid1), .busy(busy1), .frame_err(ferr1), .overrun(ovr1)
  );

  uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .rx(rx16), .read_en(re16), .data(data16),
    .valid(valid16), .busy(busy16), .frame_err(ferr16), .overrun(ovr16)
  );

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic line[$];
  logic rdq[$];

  int         r_first_valid, r_ferr_cnt, r_ferr_k, r_busy_last;
  logic [7:0] r_data[$];
  int         r_read_k[$];

  bit         exp_busy[$], exp_ferr[$];
  int         exp_k[$];
  logic [7:0] exp_b[$];

  typedef struct {
    logic [7:0] b;
    logic       stop_ok;
    int         exp_valid_k;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[6];

  function automatic logic cur_valid(); return sel ? valid16 : valid1; endfunction
  function automatic logic cur_busy();  return sel ? busy16  : busy1;  endfunction
  function automatic logic cur_ferr();  return sel ? ferr16  : ferr1;  endfunction
  function automatic logic cur_ovr();   return sel ? ovr16   : ovr1;   endfunction
  function automatic logic [7:0] cur_data(); return sel ? data16 : data1; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic re);
    if (sel) begin rx16 = v; re16 = re; end
    else begin rx1 = v; re1 = re; end
  endtask

  task automatic push_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin line.push_back(v); rdq.push_back(1'b0); end
  endtask

  task automatic push_frame(input int c, input logic [7:0] b, input logic stop_ok);
    push_level(1'b0, c);
    for (int i = 0; i < 8; i++) push_level(b[i], c);
    push_level(stop_ok, c);
  endtask

  // Expected behaviour derived directly from the sampling rules over the whole line.
  task automatic run_model(input int c);
    int n, h, t, ss, sp, u, e;
    logic [7:0] b;
    n = line.size();
    h = (c - 1) / 2;
    t = 0;
    exp_busy = {}; exp_ferr = {}; exp_k = {}; exp_b = {};
    for (int i = 0; i < n; i++) begin exp_busy.push_back(1'b0); exp_ferr.push_back(1'b0); end
    while (t < n) begin
      if (line[t] === 1'b1) begin
        t++;
      end else begin
        ss = t + h;
        sp = t + h + 9 * c;
        if (ss < n && line[ss] === 1'b1) begin
          e = ss;
        end else if (sp >= n) begin
          e = n - 1;
        end else begin
          for (int i = 0; i < 8; i++) b[i] = line[t + h + (i + 1) * c];
          if (line[sp] === 1'b1) begin
            e = sp;
            exp_k.push_back(sp + 1);
            exp_b.push_back(b);
          end else begin
            u = sp + 1;
            while (u < n && line[u] !== 1'b1) u++;
            e = u;
            if (sp + 1 < n) exp_ferr[sp + 1] = 1'b1;
          end
        end
        for (int i = t + 1; i <= e && i < n; i++) exp_busy[i] = 1'b1;
        t = e + 1;
      end
    end
  endtask

  // Plays line/rdq one cycle per entry; outputs seen at step k belong to cycle k.
  task automatic play(input bit auto_read, input bit use_model);
    logic re;
    r_first_valid = -1; r_ferr_cnt = 0; r_ferr_k = -1; r_busy_last = -1;
    r_data = {}; r_read_k = {};
    for (int k = 0; k < line.size(); k++) begin
      @(negedge clk);
      if (cur_valid() && r_first_valid < 0) r_first_valid = k;
      if (cur_ferr()) begin
        r_ferr_cnt++;
        if (r_ferr_k < 0) r_ferr_k = k;
      end
      if (cur_busy()) r_busy_last = k;
      if (use_model) begin
        chk($sformatf("rand_busy[%0d]", k), cur_busy(), exp_busy[k]);
        chk($sformatf("rand_ferr[%0d]", k), cur_ferr(), exp_ferr[k]);
        chk($sformatf("rand_ovr[%0d]", k), cur_ovr(), 1'b0);
      end
      re = rdq[k];
      if (auto_read && cur_valid()) begin
        re = 1'b1;
        r_data.push_back(cur_data());
        r_read_k.push_back(k);
      end
      drive(line[k], re);
    end
    @(negedge clk);
    drive(1'b1, 1'b0);
    line = {};
    rdq = {};
  endtask

  task automatic run_random(input int c, input int nseg);
    int kind;
    logic [7:0] b;
    line = {}; rdq = {};
    push_level(1'b1, 2 * c);
    for (int s = 0; s < nseg; s++) begin
      kind = $urandom_range(0, 5);
      b = 8'($urandom);
      if (kind == 0 && c > 2) push_level(1'b0, $urandom_range(1, (c - 1) / 2));
      else push_frame(c, b, kind != 1);
      if (kind == 1) push_level(1'b0, $urandom_range(0, 3 * c));
      push_level(1'b1, $urandom_range(0, 2 * c));
    end
    push_level(1'b1, 12 * c);
    run_model(c);
    play(1'b1, 1'b1);
    chk("rand_count", r_read_k.size(), exp_k.size());
    for (int i = 0; i < exp_k.size() && i < r_read_k.size(); i++) begin
      chk($sformatf("rand_k[%0d]", i), r_read_k[i], exp_k[i]);
      chk($sformatf("rand_byte[%0d]", i), r_data[i], exp_b[i]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, cur_data(), 8'h00);
    chk({tag, "_valid"}, cur_valid(), 1'b0);
    chk({tag, "_busy"}, cur_busy(), 1'b0);
    chk({tag, "_ferr"}, cur_ferr(), 1'b0);
    chk({tag, "_ovr"}, cur_ovr(), 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 10, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 10, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 10, 8'hFF, 0};
    vecs[3] = '{8'h80, 1'b1, 10, 8'h80, 0};
    vecs[4] = '{8'h55, 1'b0, -1, 8'h00, 1};
    vecs[5] = '{8'h01, 1'b1, 10, 8'h01, 0};

    repeat (2) @(negedge clk);
    sel = 1'b0; chk_all_zero("reset1");
    sel = 1'b1; chk_all_zero("reset16");
    rst = 1'b0;

    // Table: single frames at one clock per bit, valid 10 cycles after t0
    sel = 1'b0;
    for (int v = 0; v < 6; v++) begin
      push_frame(1, vecs[v].b, vecs[v].stop_ok);
      push_level(1'b1, 6);
      play(1'b1, 1'b0);
      chk($sformatf("tbl%0d_valid_k", v), r_first_valid, vecs[v].exp_valid_k);
      chk($sformatf("tbl%0d_nbytes", v), r_data.size(), (vecs[v].exp_valid_k >= 0) ? 1 : 0);
      if (r_data.size() > 0) chk($sformatf("tbl%0d_data", v), r_data[0], vecs[v].exp_data);
      chk($sformatf("tbl%0d_ferr_cnt", v), r_ferr_cnt, vecs[v].exp_ferr);
      chk($sformatf("tbl%0d_ferr_k", v), r_ferr_k, (vecs[v].exp_ferr != 0) ? 10 : -1);
    end

    // Back-to-back frames at 16 clocks per bit
    sel = 1'b1;
    push_level(1'b1, 4);
    push_frame(16, 8'h3C, 1'b1);
    push_frame(16, 8'hC3, 1'b1);
    push_level(1'b1, 20);
    play(1'b1, 1'b0);
    chk("b2b_nbytes", r_read_k.size(), 2);
    if (r_read_k.size() == 2) begin
      chk("b2b_k0", r_read_k[0], 4 + 152);
      chk("b2b_d0", r_data[0], 8'h3C);
      chk("b2b_k1", r_read_k[1], 164 + 152);
      chk("b2b_d1", r_data[1], 8'hC3);
    end

    // Short low glitch is rejected at the start sample
    push_level(1'b1, 4);
    push_level(1'b0, 3);
    push_level(1'b1, 40);
    play(1'b1, 1'b0);
    chk("glitch_valid", r_first_valid, -1);
    chk("glitch_busy_last", r_busy_last, 4 + 7);
    chk("glitch_ferr", r_ferr_cnt, 0);

    // Bad stop bit followed by a held-low line
    sel = 1'b0;
    push_level(1'b1, 2);
    push_frame(1, 8'h55, 1'b0);
    push_level(1'b0, 40);
    push_level(1'b1, 10);
    play(1'b1, 1'b0);
    chk("brk_ferr_cnt", r_ferr_cnt, 1);
    chk("brk_ferr_k", r_ferr_k, 12);
    chk("brk_valid", r_first_valid, -1);
    chk("brk_busy_last", r_busy_last, 52);

    // Overrun: second byte dropped while the first is unread
    push_level(1'b1, 2);
    push_frame(1, 8'h11, 1'b1);
    push_level(1'b1, 1);
    push_frame(1, 8'h22, 1'b1);
    push_level(1'b1, 4);
    play(1'b0, 1'b0);
    chk("ovr_valid_k", r_first_valid, 12);
    @(negedge clk);
    chk("ovr_data", data1, 8'h11);
    chk("ovr_valid", valid1, 1'b1);
    chk("ovr_flag", ovr1, 1'b1);
    drive(1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0);
    chk("ovr_clr_valid", valid1, 1'b0);
    chk("ovr_clr_flag", ovr1, 1'b0);

    // Read in the stop-sample cycle makes room for the new byte
    push_level(1'b1, 2);
    push_frame(1, 8'h11, 1'b1);
    push_level(1'b1, 1);
    push_frame(1, 8'h22, 1'b1);
    push_level(1'b1, 4);
    rdq[22] = 1'b1;
    play(1'b0, 1'b0);
    @(negedge clk);
    chk("swap_data", data1, 8'h22);
    chk("swap_valid", valid1, 1'b1);
    chk("swap_ovr", ovr1, 1'b0);
    drive(1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0);
    chk("swap_clr_valid", valid1, 1'b0);

    // Reset during data bit 4, then a clean frame
    sel = 1'b1;
    push_frame(16, 8'h99, 1'b1);
    while (line.size() > 16 * 5 + 8) begin void'(line.pop_back()); void'(rdq.pop_back()); end
    play(1'b0, 1'b0);
    chk("mid_busy", busy16, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    push_level(1'b1, 4);
    push_frame(16, 8'h7E, 1'b1);
    push_level(1'b1, 20);
    play(1'b1, 1'b0);
    chk("post_rst_nbytes", r_data.size(), 1);
    if (r_data.size() == 1) begin
      chk("post_rst_k", r_read_k[0], 4 + 152);
      chk("post_rst_data", r_data[0], 8'h7E);
    end

    // Randomized traffic against the line-level model
    sel = 1'b0;
    run_random(1, 40);
    sel = 1'b1;
    run_random(16, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
